fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register for the single-issue RV32I core.
- Holds the PC and issues one word read at a time to instruction memory.
- Captures each returned instruction, with its PC and PC+4, for the decode stage. That stage includes the immediate generator, which takes id_opcode and id_instr.
- Handles stall back-pressure through a one-entry skid buffer, and branch/jump redirects by discarding stale responses.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_skid_buffer.sv | 37 +++
 rtl/fetch_stage.sv | 138 +++++++++++++
 tb/tb_fetch_stage.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
// Imported by fetch_stage and fetch_skid_buffer.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        HOLD,
        DROP
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          PC_STEP   = 4;

endpackage

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: one-entry {instr, pc} holding register that parks a
// returned instruction while decode is stalled.
module fetch_skid_buffer
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             unload,
    input  logic             clear,
    input  logic [WIDTH-1:0] wr_instr,
    input  logic [WIDTH-1:0] wr_pc,
    output logic             full,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] pc
);

    // Entry storage; clear wins over load so a flush never keeps stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full  <= 1'b0;
            instr <= WIDTH'(NOP_INSTR);
            pc    <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full  <= 1'b1;
            instr <= wr_instr;
            pc    <= wr_pc;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC sequencing, single-outstanding instruction reads and the
// IF/ID register, with a skid entry for stall and response dropping on redirect.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ready,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             id_valid,
    output logic [WIDTH-1:0] id_instr,
    output logic [6:0]       id_opcode,
    output logic [WIDTH-1:0] id_pc,
    output logic [WIDTH-1:0] id_pc_plus4
);

    localparam logic [WIDTH-1:0] STEP  = WIDTH'(PC_STEP);
    localparam logic [WIDTH-1:0] NOP   = WIDTH'(NOP_INSTR);
    localparam logic [WIDTH-1:0] ALIGN = WIDTH'(3);

    fetch_state_t     state;
    fetch_state_t     state_next;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] redirect_target;
    logic             accept;
    logic             rsp;
    logic             slot_free;
    logic             outstanding;
    logic             load_mem;
    logic             skid_load;
    logic             skid_unload;
    logic             id_load;
    logic             skid_full;
    logic [WIDTH-1:0] skid_instr;
    logic [WIDTH-1:0] skid_pc;
    logic [WIDTH-1:0] load_instr;
    logic [WIDTH-1:0] load_pc;

    assign pc_inc          = pc + STEP;
    assign redirect_target = redirect_pc & ~ALIGN;
    assign accept          = imem_req && imem_ready;
    assign rsp             = (state == WAIT) && imem_rvalid;
    assign slot_free       = !id_valid || !stall;
    assign outstanding     = accept
                           || (((state == WAIT) || (state == DROP))
                               && !imem_rvalid);

    assign load_mem    = rsp && slot_free && !redirect_valid;
    assign skid_load   = rsp && !slot_free && !redirect_valid;
    assign skid_unload = (state == HOLD) && !stall && !redirect_valid;
    assign id_load     = load_mem || skid_unload;
    assign load_instr  = skid_unload ? skid_instr : imem_rdata;
    assign load_pc     = skid_unload ? skid_pc : pc;
    assign id_opcode   = id_instr[6:0];

    fetch_skid_buffer #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (skid_load),
        .unload  (skid_unload),
        .clear   (redirect_valid),
        .wr_instr(imem_rdata),
        .wr_pc   (pc),
        .full    (skid_full),
        .instr   (skid_instr),
        .pc      (skid_pc)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= state_next;
    end

    // Next state; a redirect waits out any request still in flight.
    always_comb begin
        state_next = state;
        if (redirect_valid) begin
            state_next = outstanding ? DROP : FETCH;
        end else begin
            unique case (state)
                FETCH: if (accept) state_next = WAIT;
                WAIT: begin
                    if (imem_rvalid) state_next = slot_free ? FETCH : HOLD;
                end
                HOLD: if (!stall) state_next = FETCH;
                DROP: if (imem_rvalid) state_next = FETCH;
                default: state_next = FETCH;
            endcase
        end
    end

    // Memory request outputs; held low during reset and while the skid is full.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc;
        if (!rst && (state == FETCH) && !skid_full) imem_req = 1'b1;
    end

    // PC advances once per accepted response; redirect overrides.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 pc <= RESET_PC;
        else if (redirect_valid) pc <= redirect_target;
        else if (rsp)            pc <= pc_inc;
    end

    // IF/ID register: load from memory or skid, drop when consumed or flushed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid    <= 1'b0;
            id_instr    <= NOP;
            id_pc       <= '0;
            id_pc_plus4 <= STEP;
        end else if (redirect_valid) begin
            id_valid <= 1'b0;
        end else if (id_load) begin
            id_valid    <= 1'b1;
            id_instr    <= load_instr;
            id_pc       <= load_pc;
            id_pc_plus4 <= load_pc + STEP;
        end else if (!stall) begin
            id_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized scoreboard bench for fetch_stage.
// Memory returns addr>>2 as data; expected deliveries come from a fetch-order model.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [6:0]  id_opcode;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;

    logic        imem_req_w;
    logic [31:0] imem_addr_w;
    logic        imem_rvalid_w = 1'b0;
    logic [31:0] imem_rdata_w = 32'h0;
    logic        id_valid_w;
    logic [31:0] id_instr_w;
    logic [6:0]  id_opcode_w;
    logic [31:0] id_pc_w;
    logic [31:0] id_pc_plus4_w;

    int n_tests = 0;
    int n_fail  = 0;
    int n_deliv = 0;
    int cyc     = 0;
    int c0;
    int d0;
    bit seen;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fetch_stage #(.WIDTH(32), .RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_valid      (id_valid),
        .id_instr      (id_instr),
        .id_opcode     (id_opcode),
        .id_pc         (id_pc),
        .id_pc_plus4   (id_pc_plus4)
    );

    fetch_stage #(.WIDTH(32), .RESET_PC(WRAP_PC)) dut_w (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req_w),
        .imem_addr     (imem_addr_w),
        .imem_ready    (1'b1),
        .imem_rvalid   (imem_rvalid_w),
        .imem_rdata    (imem_rdata_w),
        .stall         (1'b0),
        .redirect_valid(1'b0),
        .redirect_pc   (32'h0),
        .id_valid      (id_valid_w),
        .id_instr      (id_instr_w),
        .id_opcode     (id_opcode_w),
        .id_pc         (id_pc_w),
        .id_pc_plus4   (id_pc_plus4_w)
    );

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory model for the main DUT: one outstanding read, variable latency.
    bit          rnd_mode = 1'b0;
    int          fixed_lat = 1;
    bit          acc_s = 1'b0;
    logic [31:0] acc_addr = 32'h0;
    bit          pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = 32'h0;

    always @(posedge clk) begin
        #1;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (acc_s) begin
                pend  = 1'b1;
                paddr = acc_addr;
                cnt   = rnd_mode ? int'($urandom_range(3, 1)) : fixed_lat;
            end
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = paddr >> 2;
                    pend        = 1'b0;
                end
            end
        end
        imem_ready = rnd_mode ? ($urandom_range(3, 0) != 0) : 1'b1;
    end

    // Zero-wait memory for the wrap-around instance.
    bit          acc_w = 1'b0;
    logic [31:0] addr_w_s = 32'h0;

    always @(negedge clk) begin
        acc_w    = !rst && imem_req_w;
        addr_w_s = imem_addr_w;
    end

    always @(posedge clk) begin
        #1;
        imem_rvalid_w = acc_w && !rst;
        imem_rdata_w  = addr_w_s >> 2;
    end

    // Reference model and scoreboard: accepted fetches queue up in address
    // order; a redirect discards them; each fresh id_valid pops one.
    logic [31:0] q[$];
    logic [31:0] exp_fetch = RESET_PC;
    logic [31:0] exp_e;
    bit          prev_hold = 1'b0;
    logic [31:0] p_instr;
    logic [31:0] p_pc;
    logic [31:0] p_pc4;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            exp_fetch = RESET_PC;
            prev_hold = 1'b0;
            acc_s     = 1'b0;
        end else begin
            acc_s    = imem_req && imem_ready;
            acc_addr = imem_addr;
            if (acc_s) begin
                check("fetch addr", imem_addr, exp_fetch);
                q.push_back(exp_fetch);
                exp_fetch = exp_fetch + 32'd4;
            end
            if (prev_hold) begin
                check("hold id_valid", 32'(id_valid), 32'd1);
                check("hold id_instr", id_instr, p_instr);
                check("hold id_pc", id_pc, p_pc);
                check("hold id_pc_plus4", id_pc_plus4, p_pc4);
            end else if (id_valid) begin
                n_deliv++;
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL deliver: got id_pc %h expected none", id_pc);
                end else begin
                    exp_e = q.pop_front();
                    check("id_pc", id_pc, exp_e);
                    check("id_instr", id_instr, exp_e >> 2);
                    check("id_pc_plus4", id_pc_plus4, exp_e + 32'd4);
                    check("id_opcode", 32'(id_opcode), (exp_e >> 2) & 32'h7F);
                end
            end
            prev_hold = id_valid && stall && !redirect_valid;
            p_instr   = id_instr;
            p_pc      = id_pc;
            p_pc4     = id_pc_plus4;
            if (redirect_valid) begin
                q.delete();
                exp_fetch = redirect_pc & ~32'h3;
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst id_valid", 32'(id_valid), 32'd0);
        check("rst id_instr", id_instr, 32'h13);
        check("rst id_pc", id_pc, 32'h0);
        check("rst id_pc_plus4", id_pc_plus4, 32'h4);
        check("rst imem_req", 32'(imem_req), 32'd0);

        // Reset release, zero-latency memory.
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("first req", 32'(imem_req), 32'd1);
        check("first addr", imem_addr, RESET_PC);
        c0 = cyc;
        for (int k = 0; k < 20 && !id_valid; k++) @(negedge clk);
        check("first id latency", 32'(cyc - c0), 32'd2);
        check("wrap id_valid", 32'(id_valid_w), 32'd1);
        check("wrap id_pc", id_pc_w, WRAP_PC);
        check("wrap id_pc_plus4", id_pc_plus4_w, 32'h0);
        check("wrap id_instr", id_instr_w, WRAP_PC >> 2);
        check("wrap id_opcode", 32'(id_opcode_w), 32'h7F);
        check("wrap next req", 32'(imem_req_w), 32'd1);
        check("wrap next addr", imem_addr_w, 32'h0);

        // Stall with 0x8 in IF/ID while 0xC returns into the skid.
        for (int k = 0; k < 20 && !(id_valid && id_pc == 32'h4); k++)
            @(negedge clk);
        check("reach pc 4", 32'(id_valid && id_pc == 32'h4), 32'd1);
        @(posedge clk);
        #1 stall = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall id_valid", 32'(id_valid), 32'd1);
            check("stall id_pc", id_pc, 32'h8);
            if (i == 2) check("skid full", 32'(dut.u_skid.full), 32'd1);
        end
        @(posedge clk);
        #1 stall = 1'b0;
        @(negedge clk);
        check("release id_pc", id_pc, 32'h8);
        @(negedge clk);
        check("unskid id_valid", 32'(id_valid), 32'd1);
        check("unskid id_pc", id_pc, 32'hC);
        check("resume req", 32'(imem_req), 32'd1);
        check("resume addr", imem_addr, 32'h10);

        // Redirect while 0x14 is outstanding with 3-cycle latency.
        fixed_lat = 3;
        for (int k = 0; k < 40 && !(imem_req && imem_ready
                                    && imem_addr == 32'h14); k++)
            @(negedge clk);
        check("req 0x14 seen", imem_addr, 32'h14);
        @(posedge clk);
        #1 redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        @(negedge clk);
        seen = 1'b0;
        for (int k = 0; k < 20 && !imem_req; k++) begin
            seen |= id_valid;
            @(negedge clk);
        end
        check("drop id_valid", 32'(seen), 32'd0);
        check("redirect req", 32'(imem_req), 32'd1);
        check("redirect addr", imem_addr, 32'h100);

        // Redirect to unaligned 0x203 while stalled with a live instruction.
        fixed_lat = 1;
        @(posedge clk);
        #1 stall = 1'b1;
        for (int k = 0; k < 20 && !id_valid; k++) @(negedge clk);
        check("held before redirect", 32'(id_valid), 32'd1);
        @(posedge clk);
        #1 redirect_valid = 1'b1;
        redirect_pc = 32'h203;
        @(negedge clk);
        check("valid in redirect cyc", 32'(id_valid), 32'd1);
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        check("valid after redirect", 32'(id_valid), 32'd0);
        for (int k = 0; k < 20 && !imem_req; k++) @(negedge clk);
        check("aligned req", 32'(imem_req), 32'd1);
        check("aligned addr", imem_addr, 32'h200);

        // Randomized traffic.
        rnd_mode = 1'b1;
        repeat (3000) begin
            @(posedge clk);
            #1;
            stall          = ($urandom_range(9, 0) < 3);
            redirect_valid = ($urandom_range(24, 0) == 0);
            redirect_pc    = ($urandom_range(3, 0) == 0)
                           ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                           : ($urandom & 32'hFFF);
        end
        @(posedge clk);
        #1 stall = 1'b0;
        redirect_valid = 1'b0;
        rnd_mode = 1'b0;
        fixed_lat = 1;
        repeat (10) @(negedge clk);

        // Asynchronous reset in the middle of a WAIT.
        fixed_lat = 3;
        @(posedge clk);
        #1 stall = 1'b1;
        for (int k = 0; k < 40 && !(id_valid && imem_req && imem_ready); k++)
            @(negedge clk);
        check("pre-reset accept", 32'(id_valid && imem_req), 32'd1);
        @(posedge clk);
        #3;
        check("pre-reset id_valid", 32'(id_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("async id_valid", 32'(id_valid), 32'd0);
        check("async id_instr", id_instr, 32'h13);
        check("async id_pc_plus4", id_pc_plus4, 32'h4);
        check("async imem_req", 32'(imem_req), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        stall = 1'b0;
        fixed_lat = 1;
        @(negedge clk);
        check("restart req", 32'(imem_req), 32'd1);
        check("restart addr", imem_addr, RESET_PC);
        d0 = n_deliv;
        repeat (20) @(negedge clk);
        check("restart deliveries", 32'(n_deliv - d0 >= 8), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
